uart_cfg_ctrl: RTL and testbench
================================

Name: uart_cfg_ctrl

Overview:
Configuration sequencer for the UART Tx/Rx pair. Accepts a new line configuration (data bits, stop bits, parity enable, baud select) from a host over a valid/ready handshake. Quiesces Tx and Rx by gating their enables and waiting for in-flight frames to drain, with a bounded timeout. Applies the new settings atomically, holds a settle period, then re-enables both directions.

Parameters:
SettleCycles, 16, cycles Tx/Rx stay disabled after new config is applied (min 1)
DrainTimeout, 200000, max cycles waited in DRAIN for tx_busy_i/rx_busy_i to clear before a forced apply (min 1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
cfg_valid_i  in  1  host config request valid
cfg_ready_o  out  1  controller can accept config
cfg_data_i  in  5  {data_bits_s[1:0], stop_bits_s[1:0], parity_en}; data 0..3 = 5..8 bits, stop 0..2 = 1..3 bits
cfg_baud_i  in  2  baud select, 00=9600, 01=19200, 10=115200, 11=256000
tx_busy_i  in  1  Tx frame in progress
rx_busy_i  in  1  Rx frame in progress
tx_en_o  out  1  Tx enable
rx_en_o  out  1  Rx enable
uart_cfg_o  out  5  applied config, same encoding as cfg_data_i
baud_sel_o  out  2  applied baud select
cfg_update_o  out  1  one-cycle pulse when new config is applied
busy_o  out  1  high whenever FSM is not in IDLE
cfg_err_o  out  1  sticky: last request rejected (stop encoding 2'b11)
timeout_o  out  1  sticky: last apply was forced by drain timeout

Behaviour:
- Reset state (all outputs registered):
  - FSM = SETTLE, settle counter = 0, tx_en_o = rx_en_o = 0.
  - uart_cfg_o = 5'b11000 (8 data bits, 1 stop bit, no parity); baud_sel_o = 2'b00.
  - cfg_update_o = 0, cfg_err_o = 0, timeout_o = 0, busy_o = 1, cfg_ready_o = 0.
- Reset mid-operation: immediately returns to the reset state; any pending request is discarded.
- FSM states: IDLE, DRAIN, APPLY, SETTLE.
- IDLE:
  - cfg_ready_o = 1; tx_en_o = rx_en_o = 1.
  - A handshake (valid & ready) latches cfg_data_i and cfg_baud_i into a pending register.
  - If stop_bits_s == 2'b11: request is discarded, cfg_err_o set to 1, FSM stays in IDLE.
  - Otherwise: cfg_err_o cleared, timeout_o cleared, next state DRAIN.
- DRAIN:
  - On entry, tx_en_o = 0 (no new Tx frame may start). rx_en_o stays 1 so an in-flight Rx frame completes.
  - Cycle counter increments each cycle.
  - When tx_busy_i == 0 and rx_busy_i == 0 in the same cycle: next state APPLY.
  - When counter reaches DrainTimeout-1 with busy still set: timeout_o = 1, next state APPLY.
  - Busy-clear takes precedence over timeout in the same cycle (timeout_o stays 0).
- APPLY (exactly 1 cycle):
  - rx_en_o = 0, tx_en_o = 0.
  - uart_cfg_o and baud_sel_o load the pending values on the entry edge, so they are visible during the APPLY cycle.
  - cfg_update_o = 1 for this cycle only. Next state SETTLE; settle counter cleared.
- SETTLE:
  - Enables held low; counter counts 0..SettleCycles-1, then next state IDLE.
  - tx_en_o and rx_en_o rise together on the cycle IDLE is entered.
- Latency:
  - Request accept to cfg_update_o = 2 cycles (IDLE→DRAIN→APPLY) when both busies are already low.
  - cfg_update_o to enables high = SettleCycles + 1 cycles.
- cfg_ready_o is low in every state except IDLE; the host holds cfg_valid_i and data stable until accepted.
- Applying a config identical to the current one still runs the full sequence.
- Counter widths are $clog2 of the parameter plus 1; counters saturate and never wrap.
- uart_cfg_o and baud_sel_o change only in APPLY.

Decomposition:
- uart_pkg gains:
  - packed struct uart_cfg_t {data_bits_s[1:0], stop_bits_s[1:0], parity_en};
  - enum cfg_state_e {IDLE, DRAIN, APPLY, SETTLE};
  - constants UartCfgDefault = 5'b11000 and BaudDefault = 2'b00.
- StopCfgWidth, DataCfgWidth and TotalCfgWidth are reused from the existing shared definitions.
- No sub-module: a single FSM plus two counters fits comfortably in one file.

Test Plan:
- Reset release, busies low → enables low for 16 cycles, then tx_en_o = rx_en_o = 1; uart_cfg_o = 5'b11000, baud_sel_o = 00, cfg_ready_o = 1.
- Idle, send cfg_data = 5'b00101 (5 data, 3 stop, parity), baud = 10 → cfg_update_o pulses 2 cycles after accept; uart_cfg_o = 5'b00101, baud_sel_o = 10; enables high 17 cycles after the pulse.
- tx_busy_i held high for 50 cycles after accept → tx_en_o = 0 at once, rx_en_o stays 1; apply occurs the cycle after busy drops; timeout_o = 0.
- DrainTimeout = 100, rx_busy_i stuck high → apply forced after 100 DRAIN cycles; timeout_o = 1 until the next valid request is accepted.
- Send stop_bits_s = 11 → accepted, cfg_err_o = 1, no cfg_update_o, outputs unchanged; a following valid request clears cfg_err_o.
- Assert rst_ni low during DRAIN → all outputs return to reset values asynchronously; the pending config is never applied.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART line-configuration types and constants used by the config sequencer.
package uart_pkg;

   localparam int DataCfgWidth  = 2;
   localparam int StopCfgWidth  = 2;
   localparam int TotalCfgWidth = DataCfgWidth + StopCfgWidth + 1;
   localparam int BaudSelWidth  = 2;

   typedef struct packed {
      logic [DataCfgWidth-1:0] data_bits_s;
      logic [StopCfgWidth-1:0] stop_bits_s;
      logic                    parity_en;
   } uart_cfg_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      APPLY,
      SETTLE
   } cfg_state_e;

   localparam uart_cfg_t                UartCfgDefault = 5'b11000;
   localparam logic [BaudSelWidth-1:0]  BaudDefault    = 2'b00;
   // Stop-bit code 3 has no meaning on the line and is rejected.
   localparam logic [StopCfgWidth-1:0]  StopInvalid    = 2'b11;

endpackage

// File: rtl/uart_cfg_ctrl.sv
// Sequences a host line-config change: gate Tx/Rx, drain in-flight frames
// (bounded by a timeout), apply the new settings atomically, settle, re-enable.
module uart_cfg_ctrl
   import uart_pkg::*;
#(
   parameter int SettleCycles = 16,
   parameter int DrainTimeout = 200000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [TotalCfgWidth-1:0] cfg_data_i,
   input  logic [BaudSelWidth-1:0]  cfg_baud_i,
   input  logic                     tx_busy_i,
   input  logic                     rx_busy_i,
   output logic                     tx_en_o,
   output logic                     rx_en_o,
   output logic [TotalCfgWidth-1:0] uart_cfg_o,
   output logic [BaudSelWidth-1:0]  baud_sel_o,
   output logic                     cfg_update_o,
   output logic                     busy_o,
   output logic                     cfg_err_o,
   output logic                     timeout_o
);

   localparam int SettleW = $clog2(SettleCycles) + 1;
   localparam int DrainW  = $clog2(DrainTimeout) + 1;
   localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
   localparam logic [DrainW-1:0]  DrainLast  = DrainW'(DrainTimeout - 1);

   cfg_state_e                state_q, state_d;
   logic [SettleW-1:0]        settle_cnt_q, settle_cnt_d;
   logic [DrainW-1:0]         drain_cnt_q, drain_cnt_d;
   uart_cfg_t                 pend_cfg_q, pend_cfg_d;
   logic [BaudSelWidth-1:0]   pend_baud_q, pend_baud_d;
   uart_cfg_t                 cfg_q, cfg_d;
   logic [BaudSelWidth-1:0]   baud_q, baud_d;
   logic                      tx_en_q, tx_en_d;
   logic                      rx_en_q, rx_en_d;
   logic                      upd_q, upd_d;
   logic                      busy_q, busy_d;
   logic                      ready_q, ready_d;
   logic                      err_q, err_d;
   logic                      tmo_q, tmo_d;

   uart_cfg_t req_cfg;
   logic      handshake, req_bad, drain_clear, drain_expire;

   assign req_cfg      = uart_cfg_t'(cfg_data_i);
   assign handshake    = cfg_valid_i & ready_q;
   assign req_bad      = (req_cfg.stop_bits_s == StopInvalid);
   assign drain_clear  = ~tx_busy_i & ~rx_busy_i;
   assign drain_expire = (drain_cnt_q == DrainLast);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= SETTLE;
         settle_cnt_q <= '0;
         drain_cnt_q  <= '0;
         pend_cfg_q   <= UartCfgDefault;
         pend_baud_q  <= BaudDefault;
         cfg_q        <= UartCfgDefault;
         baud_q       <= BaudDefault;
         tx_en_q      <= 1'b0;
         rx_en_q      <= 1'b0;
         upd_q        <= 1'b0;
         busy_q       <= 1'b1;
         ready_q      <= 1'b0;
         err_q        <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         pend_cfg_q   <= pend_cfg_d;
         pend_baud_q  <= pend_baud_d;
         cfg_q        <= cfg_d;
         baud_q       <= baud_d;
         tx_en_q      <= tx_en_d;
         rx_en_q      <= rx_en_d;
         upd_q        <= upd_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (handshake && !req_bad) state_d = DRAIN;
         DRAIN:   if (drain_clear || drain_expire) state_d = APPLY;
         APPLY:   state_d = SETTLE;
         SETTLE:  if (settle_cnt_q == SettleLast) state_d = IDLE;
         default: state_d = SETTLE;
      endcase
   end

   // Counters run only in their own state and saturate at their last value.
   always_comb begin
      drain_cnt_d  = '0;
      settle_cnt_d = '0;
      pend_cfg_d   = pend_cfg_q;
      pend_baud_d  = pend_baud_q;
      err_d        = err_q;
      tmo_d        = tmo_q;
      if (state_q == DRAIN && !drain_expire) drain_cnt_d = drain_cnt_q + DrainW'(1);
      if (state_q == SETTLE) begin
         settle_cnt_d = (settle_cnt_q == SettleLast) ? settle_cnt_q : settle_cnt_q + SettleW'(1);
      end
      if (state_q == IDLE && handshake) begin
         if (req_bad) begin
            err_d = 1'b1;
         end else begin
            err_d       = 1'b0;
            tmo_d       = 1'b0;
            pend_cfg_d  = req_cfg;
            pend_baud_d = cfg_baud_i;
         end
      end
      if (state_q == DRAIN && !drain_clear && drain_expire) tmo_d = 1'b1;
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      tx_en_d = (state_d == IDLE);
      rx_en_d = (state_d == IDLE) || (state_d == DRAIN);
      upd_d   = (state_d == APPLY);
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
      cfg_d   = cfg_q;
      baud_d  = baud_q;
      if (state_d == APPLY && state_q == DRAIN) begin
         cfg_d  = pend_cfg_q;
         baud_d = pend_baud_q;
      end
   end

   assign cfg_ready_o  = ready_q;
   assign tx_en_o      = tx_en_q;
   assign rx_en_o      = rx_en_q;
   assign uart_cfg_o   = cfg_q;
   assign baud_sel_o   = baud_q;
   assign cfg_update_o = upd_q;
   assign busy_o       = busy_q;
   assign cfg_err_o    = err_q;
   assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Directed bench for uart_cfg_ctrl; applied configs are checked against a scoreboard queue.
module tb_uart_cfg_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       cfg_valid_i;
   logic       cfg_ready_o;
   logic [4:0] cfg_data_i;
   logic [1:0] cfg_baud_i;
   logic       tx_busy_i;
   logic       rx_busy_i;
   logic       tx_en_o;
   logic       rx_en_o;
   logic [4:0] uart_cfg_o;
   logic [1:0] baud_sel_o;
   logic       cfg_update_o;
   logic       busy_o;
   logic       cfg_err_o;
   logic       timeout_o;

   int errs   = 0;
   int checks = 0;

   typedef struct packed {
      logic [4:0] cfg;
      logic [1:0] baud;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk_i = ~clk_i;

   uart_cfg_ctrl #(
      .SettleCycles(16),
      .DrainTimeout(100)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cfg_valid_i (cfg_valid_i),
      .cfg_ready_o (cfg_ready_o),
      .cfg_data_i  (cfg_data_i),
      .cfg_baud_i  (cfg_baud_i),
      .tx_busy_i   (tx_busy_i),
      .rx_busy_i   (rx_busy_i),
      .tx_en_o     (tx_en_o),
      .rx_en_o     (rx_en_o),
      .uart_cfg_o  (uart_cfg_o),
      .baud_sel_o  (baud_sel_o),
      .cfg_update_o(cfg_update_o),
      .busy_o      (busy_o),
      .cfg_err_o   (cfg_err_o),
      .timeout_o   (timeout_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_tx_en"},  32'(tx_en_o),      32'd0);
      chk({tag, "_rx_en"},  32'(rx_en_o),      32'd0);
      chk({tag, "_cfg"},    32'(uart_cfg_o),   32'h18);
      chk({tag, "_baud"},   32'(baud_sel_o),   32'd0);
      chk({tag, "_update"}, 32'(cfg_update_o), 32'd0);
      chk({tag, "_err"},    32'(cfg_err_o),    32'd0);
      chk({tag, "_tmo"},    32'(timeout_o),    32'd0);
      chk({tag, "_busy"},   32'(busy_o),       32'd1);
      chk({tag, "_ready"},  32'(cfg_ready_o),  32'd0);
   endtask

   // Returns one tick after the accepting edge, i.e. in the first cycle after the IDLE cycle.
   task automatic send(input string tag, input logic [4:0] d, input logic [1:0] b);
      int tries = 0;
      cfg_data_i  = d;
      cfg_baud_i  = b;
      cfg_valid_i = 1'b1;
      while (!cfg_ready_o && tries < 50) begin
         tick();
         tries++;
      end
      chk({tag, "_ready_at_accept"}, 32'(cfg_ready_o), 32'd1);
      tick();
      cfg_valid_i = 1'b0;
   endtask

   // n = number of edges until cfg_update_o is seen high (-1 if never).
   task automatic wait_update(input string tag, input int max_cyc, output int n);
      exp_t e;
      n = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (cfg_update_o === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n > 0) begin
         chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_cfg"},  32'(uart_cfg_o), 32'(e.cfg));
            chk({tag, "_baud"}, 32'(baud_sel_o), 32'(e.baud));
         end
      end
   endtask

   // n = edges until both enables are high; u = update pulses seen on the way.
   task automatic wait_en(input int max_cyc, output int n, output int u);
      n = -1;
      u = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (cfg_update_o === 1'b1) u++;
         if (tx_en_o === 1'b1 && rx_en_o === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int u;
      rst_ni      = 1'b1;
      cfg_valid_i = 1'b0;
      cfg_data_i  = '0;
      cfg_baud_i  = '0;
      tx_busy_i   = 1'b0;
      rx_busy_i   = 1'b0;

      // Reset and boot settle
      #2 rst_ni = 1'b0;
      #1 check_reset("rst");
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      wait_en(40, n, u);
      chk("boot_en_lat", 32'(n), 32'd16);
      chk("boot_no_upd", 32'(u), 32'd0);
      chk("boot_cfg",    32'(uart_cfg_o),  32'h18);
      chk("boot_baud",   32'(baud_sel_o),  32'd0);
      chk("boot_ready",  32'(cfg_ready_o), 32'd1);
      chk("boot_busy",   32'(busy_o),      32'd0);

      // Plain request with both directions idle
      sb_q.push_back({5'b00101, 2'b10});
      send("t2", 5'b00101, 2'b10);
      chk("t2_drain_tx_en", 32'(tx_en_o),     32'd0);
      chk("t2_drain_rx_en", 32'(rx_en_o),     32'd1);
      chk("t2_drain_busy",  32'(busy_o),      32'd1);
      chk("t2_drain_ready", 32'(cfg_ready_o), 32'd0);
      wait_update("t2", 10, n);
      chk("t2_upd_lat",   32'(n),       32'd1);
      chk("t2_apply_rx",  32'(rx_en_o), 32'd0);
      wait_en(40, n, u);
      chk("t2_en_lat",    32'(n), 32'd17);
      chk("t2_upd_once",  32'(u), 32'd0);

      // Tx busy for 50 DRAIN cycles, then drops
      tx_busy_i = 1'b1;
      sb_q.push_back({5'b11010, 2'b01});
      send("t3", 5'b11010, 2'b01);
      chk("t3_tx_en", 32'(tx_en_o), 32'd0);
      chk("t3_rx_en", 32'(rx_en_o), 32'd1);
      u = 0;
      repeat (50) begin
         tick();
         if (cfg_update_o === 1'b1) u++;
      end
      chk("t3_hold_no_upd", 32'(u), 32'd0);
      tx_busy_i = 1'b0;
      wait_update("t3", 10, n);
      chk("t3_upd_lat", 32'(n),         32'd1);
      chk("t3_tmo",     32'(timeout_o), 32'd0);
      wait_en(40, n, u);
      chk("t3_en_lat",  32'(n), 32'd17);

      // Rx stuck busy: forced apply after 100 DRAIN cycles
      rx_busy_i = 1'b1;
      sb_q.push_back({5'b01001, 2'b11});
      send("t4", 5'b01001, 2'b11);
      wait_update("t4", 150, n);
      chk("t4_upd_lat", 32'(n),         32'd100);
      chk("t4_tmo",     32'(timeout_o), 32'd1);
      rx_busy_i = 1'b0;
      wait_en(40, n, u);
      chk("t4_en_lat",      32'(n),         32'd17);
      chk("t4_tmo_sticky",  32'(timeout_o), 32'd1);

      // Invalid stop encoding is rejected, then an identical valid config still sequences
      send("t5bad", 5'b10110, 2'b01);
      chk("t5_err",   32'(cfg_err_o),   32'd1);
      chk("t5_ready", 32'(cfg_ready_o), 32'd1);
      chk("t5_busy",  32'(busy_o),      32'd0);
      chk("t5_tx_en", 32'(tx_en_o),     32'd1);
      chk("t5_cfg",   32'(uart_cfg_o),  32'h09);
      chk("t5_baud",  32'(baud_sel_o),  32'd3);
      chk("t5_tmo",   32'(timeout_o),   32'd1);
      wait_update("t5none", 5, n);
      chk("t5_no_upd", 32'(n), 32'hFFFF_FFFF);
      sb_q.push_back({5'b01001, 2'b11});
      send("t5", 5'b01001, 2'b11);
      chk("t5_err_clr", 32'(cfg_err_o), 32'd0);
      chk("t5_tmo_clr", 32'(timeout_o), 32'd0);
      wait_update("t5", 10, n);
      chk("t5_upd_lat", 32'(n), 32'd1);
      wait_en(40, n, u);
      chk("t5_en_lat",  32'(n), 32'd17);

      // Reset during DRAIN discards the pending request
      tx_busy_i = 1'b1;
      send("t6", 5'b00110, 2'b10);
      repeat (3) tick();
      #2 rst_ni = 1'b0;
      #1 check_reset("t6rst");
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      tx_busy_i = 1'b0;
      wait_en(40, n, u);
      chk("t6_en_lat",   32'(n),          32'd16);
      chk("t6_no_upd",   32'(u),          32'd0);
      chk("t6_cfg",      32'(uart_cfg_o), 32'h18);
      chk("t6_baud",     32'(baud_sel_o), 32'd0);
      chk("sb_drained",  32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
